// File: rtl/bcd_pkg.sv
// Shared BCD constants and types for the BCD digit multiplier.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX        = 4'd9;
    localparam bcd_digit_t BCD_ERR_NIBBLE = 4'hF;

    function automatic logic bcd_is_invalid(input bcd_digit_t digit);
        return digit > BCD_MAX;
    endfunction

endpackage

// File: rtl/bin7_to_bcd.sv
// Combinational 7-bit binary to two BCD digits using shift-add-3 (double dabble).
module bin7_to_bcd
    import bcd_pkg::*;
(
    input  logic [6:0]  i_bin,
    output bcd_digit_t  o_tens,
    output bcd_digit_t  o_units
);

    // Working register {tens, units, binary}; the hundreds digit (inputs 100..127)
    // is shifted out of the top, leaving tens/units as the value modulo 100.
    logic [14:0] w_work;

    always_comb begin
        w_work = {8'd0, i_bin};
        for (int i = 0; i < 7; i++) begin
            if (w_work[10:7] >= 4'd5) begin
                w_work[10:7] = w_work[10:7] + 4'd3;
            end
            if (w_work[14:11] >= 4'd5) begin
                w_work[14:11] = w_work[14:11] + 4'd3;
            end
            w_work = {w_work[13:0], 1'b0};
        end
    end

    assign o_tens  = w_work[14:11];
    assign o_units = w_work[10:7];

endmodule

// File: rtl/bcd_multiplier.sv
// Single-digit BCD multiplier: one registered two-digit BCD result per accepted pair,
// with 4'hF marking the nibble of each out-of-range operand.
module bcd_multiplier
    import bcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  num1,
    input  logic [3:0]  num2,
    output logic        out_valid,
    output logic [7:0]  res,
    output logic        err
);

    logic        w_num1_bad;
    logic        w_num2_bad;
    bcd_digit_t  w_op1;
    bcd_digit_t  w_op2;
    logic [6:0]  w_product;
    bcd_digit_t  w_tens;
    bcd_digit_t  w_units;
    logic [7:0]  w_res;

    logic        r_out_valid;
    logic [7:0]  r_res;
    logic        r_err;

    assign w_num1_bad = bcd_is_invalid(num1);
    assign w_num2_bad = bcd_is_invalid(num2);

    // Invalid operands are zeroed so the 7-bit product never exceeds 81.
    assign w_op1     = w_num1_bad ? 4'd0 : num1;
    assign w_op2     = w_num2_bad ? 4'd0 : num2;
    assign w_product = {3'd0, w_op1} * {3'd0, w_op2};

    bin7_to_bcd u_bin7_to_bcd (
        .i_bin   (w_product),
        .o_tens  (w_tens),
        .o_units (w_units)
    );

    always_comb begin
        w_res = {w_tens, w_units};
        if (w_num1_bad && w_num2_bad) begin
            w_res = {BCD_ERR_NIBBLE, BCD_ERR_NIBBLE};
        end else if (w_num1_bad) begin
            w_res = {BCD_ERR_NIBBLE, 4'h0};
        end else if (w_num2_bad) begin
            w_res = {4'h0, BCD_ERR_NIBBLE};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res       <= 8'h00;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_res <= w_res;
                r_err <= w_num1_bad | w_num2_bad;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign err       = r_err;

endmodule

// File: tb/tb_bcd_multiplier.sv
// Directed and exhaustive self-checking bench for bcd_multiplier.
module tb_bcd_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] num1;
    logic [3:0] num2;
    logic       out_valid;
    logic [7:0] res;
    logic       err;

    int n_checks = 0;
    int n_fails  = 0;

    bcd_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .res       (res),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal arithmetic on integers, independent of the shift-add-3 path.
    function automatic logic [8:0] model(input int a, input int b);
        logic [3:0] hi, lo;
        logic       e;
        int         p;
        e = (a > 9) || (b > 9);
        if (a > 9 && b > 9) begin
            hi = 4'hF; lo = 4'hF;
        end else if (a > 9) begin
            hi = 4'hF; lo = 4'h0;
        end else if (b > 9) begin
            hi = 4'h0; lo = 4'hF;
        end else begin
            p  = a * b;
            hi = 4'(p / 10);
            lo = 4'(p % 10);
        end
        return {e, hi, lo};
    endfunction

    // Directed vectors: {num1, num2, expected res, expected err}
    typedef struct {
        int         a;
        int         b;
        logic [7:0] r;
        logic       e;
    } vec_t;

    vec_t vecs[8] = '{
        '{0,  3,  8'h00, 1'b0},
        '{9,  4,  8'h36, 1'b0},
        '{2,  7,  8'h14, 1'b0},
        '{9,  9,  8'h81, 1'b0},
        '{13, 3,  8'hF0, 1'b1},
        '{3,  14, 8'h0F, 1'b1},
        '{15, 10, 8'hFF, 1'b1},
        '{1,  1,  8'h01, 1'b0}
    };

    initial begin
        logic [8:0] exp_v;
        logic [7:0] held_res;

        rst      = 1'b1;
        in_valid = 1'b1;
        num1     = 4'd9;
        num2     = 4'd9;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_res",       32'(res),       32'h00);
        check("reset_err",       32'(err),       32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        check("post_reset_no_valid", 32'(out_valid), 32'd0);

        // Directed vectors, each followed by an idle cycle.
        foreach (vecs[k]) begin
            @(negedge clk);
            num1     = 4'(vecs[k].a);
            num2     = 4'(vecs[k].b);
            in_valid = 1'b1;
            @(posedge clk); #1;
            $display("dir %0d*%0d -> res=%02h err=%0b valid=%0b", vecs[k].a, vecs[k].b, res, err, out_valid);
            check("dir_valid", 32'(out_valid), 32'd1);
            check("dir_res",   32'(res),       32'(vecs[k].r));
            check("dir_err",   32'(err),       32'(vecs[k].e));
            held_res = vecs[k].r;
            @(negedge clk);
            in_valid = 1'b0;
            num1     = 4'd5;
            num2     = 4'd5;
            @(posedge clk); #1;
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_hold",  32'(res),       32'(held_res));
            check("idle_err",   32'(err),       32'(vecs[k].e));
        end

        // Exhaustive back-to-back sweep.
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            num1     = 4'(k / 16);
            num2     = 4'(k % 16);
            in_valid = 1'b1;
            @(posedge clk); #1;
            exp_v = model(k / 16, k % 16);
            $display("sweep %0d*%0d -> res=%02h err=%0b", k / 16, k % 16, res, err);
            check("sweep_valid", 32'(out_valid), 32'd1);
            check("sweep_res",   32'(res),       32'(exp_v[7:0]));
            check("sweep_err",   32'(err),       32'(exp_v[8]));
        end

        // Reset mid-stream with in_valid held high.
        @(negedge clk);
        num1     = 4'd5;
        num2     = 4'd5;
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_res",   32'(res),       32'h00);
        check("async_rst_err",   32'(err),       32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        check("discard_valid", 32'(out_valid), 32'd0);
        check("discard_res",   32'(res),       32'h00);
        @(posedge clk); #1;
        check("discard_valid2", 32'(out_valid), 32'd0);

        // First operation after reset.
        @(negedge clk);
        num1     = 4'd9;
        num2     = 4'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        $display("post_rst 9*4 -> res=%02h err=%0b valid=%0b", res, err, out_valid);
        check("first_op_valid", 32'(out_valid), 32'd1);
        check("first_op_res",   32'(res),       32'h36);
        check("first_op_err",   32'(err),       32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("first_op_pulse", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
